// File: rtl/arc_lut.sv
// Inverse sine/cosine: Q16.16 value -> nearest integer degree (0..359) by a fixed
// 7-step binary search over a 91-entry quarter-wave table; 10-cycle start/done latency.
module arc_lut (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_selector,
  input  logic signed [31:0] value,
  output logic        [31:0] angle,
  output logic               done,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_SEARCH, S_ROUND, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_op, r_sign, r_oor;
  logic signed [31:0] r_val;
  logic        [16:0] r_a;
  logic        [6:0]  r_lo, r_hi, r_k;
  logic        [2:0]  r_cnt;
  logic        [31:0] r_angle;
  logic               r_done, r_err;

  logic        [31:0] w_mag;
  logic        [6:0]  w_span, w_mid;
  logic        [8:0]  w_map;

  function automatic logic [16:0] sin_rom(input logic [6:0] k);
    logic [16:0] t;
    case (k)
      7'd0:  t = 17'd0;     7'd1:  t = 17'd1144;  7'd2:  t = 17'd2287;  7'd3:  t = 17'd3430;  7'd4:  t = 17'd4572;
      7'd5:  t = 17'd5712;  7'd6:  t = 17'd6850;  7'd7:  t = 17'd7987;  7'd8:  t = 17'd9121;  7'd9:  t = 17'd10252;
      7'd10: t = 17'd11380; 7'd11: t = 17'd12505; 7'd12: t = 17'd13626; 7'd13: t = 17'd14742; 7'd14: t = 17'd15855;
      7'd15: t = 17'd16962; 7'd16: t = 17'd18064; 7'd17: t = 17'd19161; 7'd18: t = 17'd20252; 7'd19: t = 17'd21336;
      7'd20: t = 17'd22415; 7'd21: t = 17'd23486; 7'd22: t = 17'd24550; 7'd23: t = 17'd25607; 7'd24: t = 17'd26656;
      7'd25: t = 17'd27697; 7'd26: t = 17'd28729; 7'd27: t = 17'd29753; 7'd28: t = 17'd30767; 7'd29: t = 17'd31772;
      7'd30: t = 17'd32768; 7'd31: t = 17'd33754; 7'd32: t = 17'd34729; 7'd33: t = 17'd35693; 7'd34: t = 17'd36647;
      7'd35: t = 17'd37590; 7'd36: t = 17'd38521; 7'd37: t = 17'd39441; 7'd38: t = 17'd40348; 7'd39: t = 17'd41243;
      7'd40: t = 17'd42126; 7'd41: t = 17'd42995; 7'd42: t = 17'd43852; 7'd43: t = 17'd44695; 7'd44: t = 17'd45525;
      7'd45: t = 17'd46341; 7'd46: t = 17'd47143; 7'd47: t = 17'd47930; 7'd48: t = 17'd48703; 7'd49: t = 17'd49461;
      7'd50: t = 17'd50203; 7'd51: t = 17'd50931; 7'd52: t = 17'd51643; 7'd53: t = 17'd52339; 7'd54: t = 17'd53020;
      7'd55: t = 17'd53684; 7'd56: t = 17'd54332; 7'd57: t = 17'd54963; 7'd58: t = 17'd55578; 7'd59: t = 17'd56175;
      7'd60: t = 17'd56756; 7'd61: t = 17'd57319; 7'd62: t = 17'd57865; 7'd63: t = 17'd58393; 7'd64: t = 17'd58903;
      7'd65: t = 17'd59396; 7'd66: t = 17'd59870; 7'd67: t = 17'd60326; 7'd68: t = 17'd60764; 7'd69: t = 17'd61183;
      7'd70: t = 17'd61584; 7'd71: t = 17'd61966; 7'd72: t = 17'd62328; 7'd73: t = 17'd62672; 7'd74: t = 17'd62997;
      7'd75: t = 17'd63303; 7'd76: t = 17'd63589; 7'd77: t = 17'd63856; 7'd78: t = 17'd64104; 7'd79: t = 17'd64332;
      7'd80: t = 17'd64540; 7'd81: t = 17'd64729; 7'd82: t = 17'd64898; 7'd83: t = 17'd65048; 7'd84: t = 17'd65177;
      7'd85: t = 17'd65287; 7'd86: t = 17'd65376; 7'd87: t = 17'd65446; 7'd88: t = 17'd65496; 7'd89: t = 17'd65526;
      7'd90: t = 17'd65536;
      default: t = 17'd0;
    endcase
    return t;
  endfunction

  // lo is the floor index (T[lo] <= a < T[lo+1]); step up only when strictly closer
  function automatic logic [6:0] round_nearest(input logic [6:0] lo, input logic [16:0] a);
    logic [16:0] t_lo, t_up;
    t_lo = sin_rom(lo);
    t_up = sin_rom(lo + 7'd1);
    if (lo < 7'd90 && (t_up - a) < (a - t_lo)) return lo + 7'd1;
    return lo;
  endfunction

  function automatic logic [8:0] map_angle(input logic op, input logic s, input logic [6:0] k);
    logic [8:0] kk;
    kk = {2'b00, k};
    if (!op) return s ? ((k == 7'd0) ? 9'd0 : 9'd360 - kk) : kk;
    return s ? 9'd90 + kk : 9'd90 - kk;
  endfunction

  // 0x80000000 negates to itself and is caught by the range compare
  assign w_mag  = r_val[31] ? 32'(-r_val) : 32'(r_val);
  assign w_span = r_hi - r_lo + 7'd1;
  assign w_mid  = r_lo + (w_span >> 1);
  assign w_map  = map_angle(r_op, r_sign, r_k);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ABS;
      S_ABS:    w_next = S_SEARCH;
      S_SEARCH: if (r_cnt == 3'd6) w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (start) begin
        r_op  <= op_selector;
        r_val <= value;
      end
      S_ABS: begin
        r_a    <= w_mag[16:0];
        r_sign <= r_val[31];
        r_oor  <= (w_mag > 32'h0001_0000);
        r_lo   <= 7'd0;
        r_hi   <= 7'd90;
        r_cnt  <= 3'd0;
      end
      S_SEARCH: begin
        if (sin_rom(w_mid) <= r_a) r_lo <= w_mid;
        else                       r_hi <= w_mid - 7'd1;
        r_cnt <= r_cnt + 3'd1;
      end
      S_ROUND: r_k <= round_nearest(r_lo, r_a);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_angle <= 32'd0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_err   <= r_oor;
        r_angle <= r_oor ? 32'd0 : {23'd0, w_map};
      end
    end
  end

  assign angle = r_angle;
  assign err   = r_err;
  assign done  = r_done;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_arc_lut.sv
// Directed and randomized checks of arc_lut against a nearest-angle reference model
// built from a real-valued sine table.
module tb_arc_lut;

  logic               clk = 1'b0;
  logic               rst, start, op_selector;
  logic signed [31:0] value;
  logic        [31:0] angle;
  logic               done, busy, err;

  int errors = 0;
  int checks = 0;
  int tbl[0:90];

  localparam real PI = 3.14159265358979323846;

  arc_lut dut (
    .clk(clk), .rst(rst), .start(start), .op_selector(op_selector),
    .value(value), .angle(angle), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi($floor(x + 0.5));
    return -$rtoi($floor(-x + 0.5));
  endfunction

  // Nearest table entry by exhaustive scan, then quadrant mapping
  task automatic model(input logic op, input int v, output int ang, output logic e);
    int a, best, bestd, d;
    e = (v > 65536) || (v < -65536);
    ang = 0;
    if (!e) begin
      a = (v < 0) ? -v : v;
      best = 0;
      bestd = 65537;
      for (int k = 0; k <= 90; k++) begin
        d = (tbl[k] > a) ? tbl[k] - a : a - tbl[k];
        if (d < bestd) begin bestd = d; best = k; end
      end
      if (!op) ang = (v < 0) ? ((best == 0) ? 0 : 360 - best) : best;
      else     ang = (v < 0) ? 90 + best : 90 - best;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One conversion: returns result, done latency (-1 if none), done count, busy profile ok
  task automatic run(input logic op, input logic [31:0] v, output logic [31:0] ang,
                     output logic e, output int lat, output int ndone, output logic bok);
    lat = -1; ndone = 0; bok = 1'b1; ang = 32'hDEAD_BEEF; e = 1'bx;
    @(negedge clk);
    start = 1'b1; op_selector = op; value = v;
    @(negedge clk);
    start = 1'b0; op_selector = ~op; value = $urandom;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      if (i < 10 && !busy) bok = 1'b0;
      if (i == 10 && busy) bok = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = i; ang = angle; e = err; end
      end
    end
  endtask

  task automatic directed(input string tag, input logic op, input logic [31:0] v,
                          input logic [31:0] exp_ang, input logic exp_err);
    logic [31:0] a; logic e; int lat, nd; logic bok;
    run(op, v, a, e, lat, nd, bok);
    check({tag, "_angle"}, a, exp_ang);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"}, lat, 10);
    check({tag, "_ndone"}, nd, 1);
    check({tag, "_busy"}, {31'd0, bok}, 32'd1);
  endtask

  task automatic vs_model(input string tag, input logic op, input int v);
    logic [31:0] a; logic e; int lat, nd; logic bok; int ma; logic me;
    model(op, v, ma, me);
    run(op, v, a, e, lat, nd, bok);
    check({tag, "_angle"}, a, ma);
    check({tag, "_err"}, {31'd0, e}, {31'd0, me});
    check({tag, "_lat"}, lat, 10);
  endtask

  initial begin
    int nd;
    logic [31:0] cap;
    for (int k = 0; k <= 90; k++) tbl[k] = rnd(65536.0 * $sin(k * PI / 180.0));

    rst = 1'b1; start = 1'b0; op_selector = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_angle", angle, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    directed("asin_30",  1'b0, 32'h0000_8000, 30,  1'b0);
    directed("acos_60",  1'b1, 32'h0000_8000, 60,  1'b0);
    directed("asin_330", 1'b0, 32'hFFFF_8000, 330, 1'b0);
    directed("acos_180", 1'b1, 32'hFFFF_0000, 180, 1'b0);
    directed("asin_90",  1'b0, 32'h0001_0000, 90,  1'b0);
    directed("asin_270", 1'b0, 32'hFFFF_0000, 270, 1'b0);
    directed("asin_0",   1'b0, 32'h0000_0000, 0,   1'b0);
    directed("acos_0",   1'b1, 32'h0000_0000, 90,  1'b0);
    directed("asin_tie", 1'b0, 32'h0000_B36D, 44,  1'b0);
    directed("asin_up",  1'b0, 32'h0000_B36E, 45,  1'b0);
    directed("acos_up",  1'b1, 32'h0000_B36E, 45,  1'b0);
    directed("oor_pos",  1'b0, 32'h0001_0001, 0,   1'b1);
    directed("after_oor", 1'b0, 32'h0000_8000, 30, 1'b0);
    directed("oor_min",  1'b1, 32'h8000_0000, 0,   1'b1);
    directed("oor_neg",  1'b0, 32'hFFFE_FFFF, 0,   1'b1);
    directed("nonzero",  1'b1, 32'h0000_8000, 60,  1'b0);

    // Second start while busy must be ignored
    @(negedge clk);
    start = 1'b1; op_selector = 1'b0; value = 32'h0000_8000;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op_selector = 1'b1; value = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    nd = 0; cap = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin nd++; cap = angle; end
    end
    check("hs_angle", cap, 30);
    check("hs_ndone", nd, 1);

    // Reset during SEARCH aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op_selector = 1'b0; value = 32'h0000_B36E;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_angle", angle, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort_ndone", nd, 0);

    for (int k = 0; k < 360; k++) begin
      vs_model("sweep_asin", 1'b0, rnd(65536.0 * $sin(k * PI / 180.0)));
      vs_model("sweep_acos", 1'b1, rnd(65536.0 * $cos(k * PI / 180.0)));
    end

    for (int n = 0; n < 60; n++) begin
      int v;
      v = int'($urandom_range(131074, 0)) - 65537;
      vs_model("rand", 1'($urandom_range(1, 0)), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
